// File: rtl/neosd_clk_gen.sv
// SD clock divider and period-strobe generator for the NEOSD host.
// Runs a glitch-free SD clock on request or for a self-timed card-init burst.
module neosd_clk_gen #(
   parameter int CDIV_W = 8,
   parameter int N_INIT = 80
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              ctrl_en_i,
   input  logic [CDIV_W-1:0] ctrl_cdiv_i,
   input  logic              ctrl_init_i,
   output logic              status_init_busy_o,
   input  logic              cmd_clk_req_i,
   input  logic              dat_clk_req_i,
   input  logic              dat_stall_i,
   output logic              clkstrb_o,
   output logic              sd_clk_en_o,
   output logic              sd_clk_o
);

   logic              en_q;
   logic              phase_q, phase_n;
   logic [CDIV_W-1:0] cnt_q, cnt_n;
   logic [CDIV_W-1:0] cdiv_q, cdiv_n;
   logic              run_q, run_n;
   logic              busy_q, busy_n;
   logic [7:0]        icnt_q, icnt_n;
   logic              strb_q, strb_n;
   logic              sdclk_q, sdclk_n;
   logic              clken_q, clken_n;

   always_comb begin
      phase_n = phase_q;
      cnt_n   = cnt_q;
      cdiv_n  = cdiv_q;
      run_n   = run_q;
      busy_n  = busy_q;
      icnt_n  = icnt_q;
      clken_n = clken_q;
      if (!ctrl_en_i) begin
         phase_n = 1'b0;
         cnt_n   = '0;
         run_n   = 1'b0;
         busy_n  = 1'b0;
         icnt_n  = '0;
         clken_n = 1'b0;
      end else if (!en_q) begin
         // first enabled edge: start a fresh (unclocked) period at cycle 0
         cdiv_n  = ctrl_cdiv_i;
         phase_n = 1'b0;
         cnt_n   = '0;
      end else if (strb_q) begin
         // period boundary: strb_q marks the last cycle of the period
         cdiv_n  = ctrl_cdiv_i;
         phase_n = 1'b0;
         cnt_n   = '0;
         if (ctrl_init_i && !busy_q) begin
            busy_n = 1'b1;
            icnt_n = 8'(N_INIT);
         end else if (busy_q && run_q) begin
            icnt_n = icnt_q - 8'd1;
            if (icnt_q == 8'd1) begin
               busy_n = 1'b0;
            end
         end
         run_n   = busy_n | ((cmd_clk_req_i | dat_clk_req_i) & ~dat_stall_i);
         clken_n = run_n;
      end else if (cnt_q == cdiv_q) begin
         phase_n = 1'b1;
         cnt_n   = '0;
      end else begin
         cnt_n = cnt_q + 1'b1;
      end
      // outputs are decoded from the next cycle's position so they stay registered
      strb_n  = ctrl_en_i & en_q & phase_n & (cnt_n == cdiv_n);
      sdclk_n = run_n & phase_n;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         en_q    <= 1'b0;
         phase_q <= 1'b0;
         cnt_q   <= '0;
         cdiv_q  <= '0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
         icnt_q  <= '0;
         strb_q  <= 1'b0;
         sdclk_q <= 1'b0;
         clken_q <= 1'b0;
      end else begin
         en_q    <= ctrl_en_i;
         phase_q <= phase_n;
         cnt_q   <= cnt_n;
         cdiv_q  <= cdiv_n;
         run_q   <= run_n;
         busy_q  <= busy_n;
         icnt_q  <= icnt_n;
         strb_q  <= strb_n;
         sdclk_q <= sdclk_n;
         clken_q <= clken_n;
      end
   end

   assign status_init_busy_o = busy_q;
   assign clkstrb_o          = strb_q;
   assign sd_clk_en_o        = clken_q;
   assign sd_clk_o           = sdclk_q;

endmodule

// File: tb/tb_neosd_clk_gen.sv
// Bench for neosd_clk_gen: period-index reference model plus directed and random steps.
module tb_neosd_clk_gen;

   localparam int CDIV_W = 8;
   localparam int N_INIT = 80;

   logic              clk_i = 1'b0;
   logic              rstn_i;
   logic              ctrl_en_i;
   logic [CDIV_W-1:0] ctrl_cdiv_i;
   logic              ctrl_init_i;
   logic              status_init_busy_o;
   logic              cmd_clk_req_i;
   logic              dat_clk_req_i;
   logic              dat_stall_i;
   logic              clkstrb_o;
   logic              sd_clk_en_o;
   logic              sd_clk_o;

   neosd_clk_gen #(.CDIV_W(CDIV_W), .N_INIT(N_INIT)) dut (
      .clk_i              (clk_i),
      .rstn_i             (rstn_i),
      .ctrl_en_i          (ctrl_en_i),
      .ctrl_cdiv_i        (ctrl_cdiv_i),
      .ctrl_init_i        (ctrl_init_i),
      .status_init_busy_o (status_init_busy_o),
      .cmd_clk_req_i      (cmd_clk_req_i),
      .dat_clk_req_i      (dat_clk_req_i),
      .dat_stall_i        (dat_stall_i),
      .clkstrb_o          (clkstrb_o),
      .sd_clk_en_o        (sd_clk_en_o),
      .sd_clk_o           (sd_clk_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // reference model: position k within a period of 2*H cycles
   int m_k, m_h, m_icnt;
   bit m_started, m_run, m_busy;

   // observation bookkeeping
   int cyc = 0, last_strb = 0, rises = 0, nstrb = 0, busy_cyc = 0;
   bit prev_clk = 1'b0;
   int intv[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_k = 0; m_h = 1; m_icnt = 0;
      m_started = 0; m_run = 0; m_busy = 0;
   endtask

   task automatic model_step();
      if (!rstn_i) begin
         model_reset();
      end else if (!ctrl_en_i) begin
         m_started = 0; m_k = 0; m_run = 0; m_busy = 0; m_icnt = 0;
      end else if (!m_started) begin
         m_started = 1; m_k = 0; m_h = int'(ctrl_cdiv_i) + 1;
      end else if (m_k == 2 * m_h - 1) begin
         m_k = 0; m_h = int'(ctrl_cdiv_i) + 1;
         if (ctrl_init_i && !m_busy) begin
            m_busy = 1; m_icnt = N_INIT;
         end else if (m_busy && m_run) begin
            m_icnt--;
            if (m_icnt == 0) m_busy = 0;
         end
         m_run = m_busy || ((cmd_clk_req_i || dat_clk_req_i) && !dat_stall_i);
      end else begin
         m_k++;
      end
   endtask

   task automatic tick();
      logic [3:0] exp_v;
      @(posedge clk_i);
      model_step();
      cyc++;
      @(negedge clk_i);
      exp_v = {m_started && (m_k == 2 * m_h - 1), m_run && (m_k >= m_h), m_run, m_busy};
      chk("outputs", {28'd0, clkstrb_o, sd_clk_o, sd_clk_en_o, status_init_busy_o}, {28'd0, exp_v});
      if (sd_clk_o && !prev_clk) rises++;
      prev_clk = sd_clk_o;
      if (clkstrb_o) begin
         intv.push_back(cyc - last_strb);
         last_strb = cyc;
         nstrb++;
      end
      if (status_init_busy_o) busy_cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_k(input int target);
      int n = 0;
      while (m_k != target && n < 64) begin
         tick();
         n++;
      end
      chk("wait_k", m_k, target);
   endtask

   task automatic clr_counts();
      rises = 0; nstrb = 0; busy_cyc = 0;
   endtask

   initial begin
      model_reset();
      rstn_i = 1'b1; ctrl_en_i = 1'b0; ctrl_cdiv_i = '0; ctrl_init_i = 1'b0;
      cmd_clk_req_i = 1'b0; dat_clk_req_i = 1'b0; dat_stall_i = 1'b0;
      #1 rstn_i = 1'b0;
      #1 chk("reset_outs", {28'd0, clkstrb_o, sd_clk_o, sd_clk_en_o, status_init_busy_o}, 32'd0);
      ticks(2);

      // cdiv=0 with a command request: SD clock at half the system clock
      ctrl_en_i = 1'b1; cmd_clk_req_i = 1'b1; ctrl_cdiv_i = 8'd0;
      rstn_i = 1'b1;
      ticks(4);
      clr_counts();
      ticks(20);
      chk("div0_strobes", nstrb, 10);
      chk("div0_rises", rises, 10);

      // cdiv=3, no requests: strobes continue, clock idle
      ctrl_cdiv_i = 8'd3; cmd_clk_req_i = 1'b0;
      ticks(12);
      clr_counts();
      ticks(16);
      chk("idle_strobes", nstrb, 2);
      chk("idle_rises", rises, 0);
      wait_k(3);
      cmd_clk_req_i = 1'b1;
      clr_counts();
      ticks(16);
      chk("req_mid_rises", rises, 1);

      // cdiv=1, data request, stall raised in the first high cycle
      ctrl_cdiv_i = 8'd1; cmd_clk_req_i = 1'b0; dat_clk_req_i = 1'b1;
      ticks(12);
      wait_k(2);
      dat_stall_i = 1'b1;
      clr_counts();
      ticks(8);
      chk("stall_rises", rises, 0);
      dat_stall_i = 1'b0;
      clr_counts();
      ticks(12);
      chk("unstall_rises", rises, 3);

      // init burst overrides stall; a repeated request during the burst is ignored
      ctrl_cdiv_i = 8'd0; dat_clk_req_i = 1'b0; dat_stall_i = 1'b1;
      ticks(8);
      clr_counts();
      ctrl_init_i = 1'b1;
      begin
         int n = 0;
         while (!status_init_busy_o && n < 8) begin
            tick();
            n++;
         end
      end
      chk("init_started", {31'd0, status_init_busy_o}, 32'd1);
      ctrl_init_i = 1'b0;
      ticks(40);
      ctrl_init_i = 1'b1;
      ticks(4);
      ctrl_init_i = 1'b0;
      ticks(200);
      chk("init_rises", rises, N_INIT);
      chk("init_busy_cycles", busy_cyc, 2 * N_INIT);
      chk("init_done_busy", {31'd0, status_init_busy_o}, 32'd0);
      chk("init_done_clk", {31'd0, sd_clk_o}, 32'd0);

      // divider change in cycle 1 only takes effect at the next boundary
      dat_stall_i = 1'b0; cmd_clk_req_i = 1'b1; ctrl_cdiv_i = 8'd1;
      ticks(10);
      wait_k(1);
      ctrl_cdiv_i = 8'd4;
      intv.delete();
      ticks(16);
      chk("cdiv_intervals", intv.size() >= 2, 1);
      if (intv.size() >= 2) begin
         chk("cdiv_period_old", intv[0], 4);
         chk("cdiv_period_new", intv[1], 10);
      end

      // disable clears everything; re-enable restarts
      ctrl_en_i = 1'b0;
      ticks(3);
      chk("disabled_outs", {28'd0, clkstrb_o, sd_clk_o, sd_clk_en_o, status_init_busy_o}, 32'd0);
      ctrl_en_i = 1'b1;
      ticks(6);

      // random stimulus against the model
      for (int i = 0; i < 600; i++) begin
         ctrl_en_i     = ($urandom_range(0, 39) != 0);
         ctrl_cdiv_i   = 8'($urandom_range(0, 3));
         ctrl_init_i   = ($urandom_range(0, 59) == 0);
         cmd_clk_req_i = $urandom_range(0, 1) == 1;
         dat_clk_req_i = $urandom_range(0, 3) == 0;
         dat_stall_i   = $urandom_range(0, 3) == 0;
         tick();
      end
      ctrl_init_i = 1'b0;

      // asynchronous reset in the middle of a high phase
      ctrl_en_i = 1'b1; ctrl_cdiv_i = 8'd2; cmd_clk_req_i = 1'b1;
      dat_clk_req_i = 1'b0; dat_stall_i = 1'b0;
      ticks(14);
      wait_k(4);
      chk("pre_rst_clk", {31'd0, sd_clk_o}, 32'd1);
      #2 rstn_i = 1'b0;
      #1 chk("async_rst_outs", {28'd0, clkstrb_o, sd_clk_o, sd_clk_en_o, status_init_busy_o}, 32'd0);
      model_reset();
      ctrl_cdiv_i = 8'd0;
      ticks(2);
      rstn_i = 1'b1;
      tick();
      chk("first_strb_early", {31'd0, clkstrb_o}, 32'd0);
      tick();
      chk("first_strb", {31'd0, clkstrb_o}, 32'd1);
      ticks(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
